// File: rtl/edge_ctrl_pkg.sv
// Shared definitions for the edge-event controller.
// Contents: per-channel edge-mode encodings, scheduler state encoding and a
// modular-add helper used by the round-robin search.
package edge_ctrl_pkg;

    // Per-channel edge select (bit 0 enables rising, bit 1 enables falling)
    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } sched_state_e;

    function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/edge_detect_cell.sv
// One trigger channel: edge detector with mode qualification feeding a
// one-deep pending latch and a sticky overflow flag.
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_armed         detection enable (low during the first cycle after reset)
//   i_trigger       trigger line, synchronous to i_clk
//   i_mode          edge select (off / rising / falling / both)
//   i_grant         scheduler takes this channel's pending event this cycle
//   i_ovf_clr       clears the overflow flag (a same-cycle set wins)
//   o_pending       event waiting to be scheduled
//   o_pend_rise     polarity of the waiting event (1 = rising)
//   o_overflow      sticky lost-event flag
module edge_detect_cell
    import edge_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_armed,
    input  logic       i_trigger,
    input  logic [1:0] i_mode,
    input  logic       i_grant,
    input  logic       i_ovf_clr,
    output logic       o_pending,
    output logic       o_pend_rise,
    output logic       o_overflow
);

    logic r_prev;
    logic r_pending;
    logic r_pend_rise;
    logic r_overflow;

    logic w_rise;
    logic w_fall;
    logic w_edge;
    logic w_pending_d;
    logic w_pend_rise_d;
    logic w_overflow_d;

    assign w_rise = i_armed & i_trigger & ~r_prev &
                    ((i_mode == EDGE_RISE) | (i_mode == EDGE_BOTH));
    assign w_fall = i_armed & ~i_trigger & r_prev &
                    ((i_mode == EDGE_FALL) | (i_mode == EDGE_BOTH));
    assign w_edge = w_rise | w_fall;

    always_comb begin
        w_pending_d   = r_pending;
        w_pend_rise_d = r_pend_rise;
        w_overflow_d  = r_overflow;

        if (i_ovf_clr) begin
            w_overflow_d = 1'b0;
        end

        if (i_mode == EDGE_OFF) begin
            w_pending_d = 1'b0;
        end else if (w_edge && r_pending && i_grant) begin
            // Old event leaves this cycle, so the new one takes its slot
            w_pend_rise_d = w_rise;
        end else if (w_edge && r_pending) begin
            w_overflow_d = 1'b1;
        end else if (w_edge) begin
            w_pending_d   = 1'b1;
            w_pend_rise_d = w_rise;
        end else if (i_grant) begin
            w_pending_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev      <= 1'b0;
            r_pending   <= 1'b0;
            r_pend_rise <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_prev      <= i_trigger;
            r_pending   <= w_pending_d;
            r_pend_rise <= w_pend_rise_d;
            r_overflow  <= w_overflow_d;
        end
    end

    assign o_pending   = r_pending;
    assign o_pend_rise = r_pend_rise;
    assign o_overflow  = r_overflow;

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller: N_CH edge detector cells share one
// valid/ready event port through a round-robin scheduler.
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_trigger       trigger lines, synchronous to i_clk
//   i_mode          per-channel edge select, bits [2i+1:2i]
//   o_evt_valid     event presented
//   i_evt_ready     consumer accepts when o_evt_valid & i_evt_ready
//   o_evt_ch        channel index of the presented event
//   o_evt_rise      1 = rising edge, 0 = falling edge
//   o_overflow      sticky per-channel lost-event flags
//   i_ovf_clr       clears all overflow flags
module edge_event_arbiter
    import edge_ctrl_pkg::*;
#(
    parameter  int unsigned N_CH = 4,
    localparam int unsigned CH_W = $clog2(N_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_CH-1:0]   i_trigger,
    input  logic [2*N_CH-1:0] i_mode,
    output logic              o_evt_valid,
    input  logic              i_evt_ready,
    output logic [CH_W-1:0]   o_evt_ch,
    output logic              o_evt_rise,
    output logic [N_CH-1:0]   o_overflow,
    input  logic              i_ovf_clr
);

    sched_state_e    r_state;
    sched_state_e    w_state_d;
    logic            r_armed;
    logic [CH_W-1:0] r_rr_ptr;
    logic [CH_W-1:0] r_evt_ch;
    logic            r_evt_rise;

    logic [N_CH-1:0] w_pending;
    logic [N_CH-1:0] w_pend_rise;
    logic [N_CH-1:0] w_grant;
    logic [CH_W-1:0] w_gnt_idx;
    logic            w_found;
    logic            w_any;
    logic            w_take;

    for (genvar g = 0; g < N_CH; g++) begin : g_cell
        edge_detect_cell u_cell (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_armed     (r_armed),
            .i_trigger   (i_trigger[g]),
            .i_mode      (i_mode[2*g +: 2]),
            .i_grant     (w_grant[g]),
            .i_ovf_clr   (i_ovf_clr),
            .o_pending   (w_pending[g]),
            .o_pend_rise (w_pend_rise[g]),
            .o_overflow  (o_overflow[g])
        );
    end

    // First pending channel at or above r_rr_ptr, wrapping past N_CH-1
    always_comb begin
        w_gnt_idx = '0;
        w_found   = 1'b0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (!w_found && w_pending[wrap_add(32'(r_rr_ptr), k, N_CH)]) begin
                w_found   = 1'b1;
                w_gnt_idx = CH_W'(wrap_add(32'(r_rr_ptr), k, N_CH));
            end
        end
    end

    assign w_any = |w_pending;

    // Output is free when idle or when the presented event is being accepted
    assign w_take  = w_any & ((r_state == ST_IDLE) | i_evt_ready);
    assign w_grant = w_take ? (N_CH'(1) << w_gnt_idx) : '0;

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (i_evt_ready && !w_any) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_armed    <= 1'b0;
            r_rr_ptr   <= '0;
            r_evt_ch   <= '0;
            r_evt_rise <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_armed <= 1'b1;
            if (w_take) begin
                r_evt_ch   <= w_gnt_idx;
                r_evt_rise <= w_pend_rise[w_gnt_idx];
                r_rr_ptr   <= CH_W'(wrap_add(32'(w_gnt_idx), 1, N_CH));
            end
        end
    end

    assign o_evt_valid = (r_state == ST_PRESENT);
    assign o_evt_ch    = r_evt_ch;
    assign o_evt_rise  = r_evt_rise;

endmodule

// File: tb/tb_edge_event_arbiter.sv
module tb_edge_event_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] trig = '0;
    logic [7:0]   mode = 8'hFF;
    logic         ready = 1'b1;
    logic         clr = 1'b0;
    logic         o_valid;
    logic [1:0]   o_ch;
    logic         o_rise;
    logic [N-1:0] o_ovf;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit [N-1:0] m_prev, m_pend, m_prise, m_ovf;
    bit         m_armed, m_valid, m_rise;
    int         m_ch, m_rr;

    typedef struct {
        logic         rst_n;
        logic [N-1:0] trig;
        logic [7:0]   mode;
        logic         rdy;
        logic         clr;
        int           reps;
        logic         vld;
        logic [1:0]   ch;
        logic         rise;
        logic [N-1:0] ovf;
    } vec_t;

    localparam int NV = 11;
    vec_t vec [NV];

    edge_event_arbiter #(.N_CH(N)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_trigger   (trig),
        .i_mode      (mode),
        .o_evt_valid (o_valid),
        .i_evt_ready (ready),
        .o_evt_ch    (o_ch),
        .o_evt_rise  (o_rise),
        .o_overflow  (o_ovf),
        .i_ovf_clr   (clr)
    );

    always #5 clk = ~clk;

    // One clock of the specified behaviour, using the inputs seen at the edge
    task automatic model_clock();
        int  g;
        bit  any, take, r, f, e;
        logic [1:0] md;
        if (!rst_n) begin
            m_prev = '0; m_pend = '0; m_prise = '0; m_ovf = '0;
            m_armed = 0; m_valid = 0; m_rise = 0; m_ch = 0; m_rr = 0;
            return;
        end
        any  = (m_pend != 0);
        take = any && (!m_valid || ready);
        g    = -1;
        if (take) begin
            for (int k = 0; k < N; k++) begin
                int c = (m_rr + k) % N;
                if (g < 0 && m_pend[c]) g = c;
            end
            m_ch    = g;
            m_rise  = m_prise[g];
            m_rr    = (g + 1) % N;
            m_valid = 1;
        end else if (m_valid && ready) begin
            m_valid = 0;
        end
        for (int c = 0; c < N; c++) begin
            md = mode[2*c +: 2];
            r  = m_armed && trig[c] && !m_prev[c] && md[0];
            f  = m_armed && !trig[c] && m_prev[c] && md[1];
            e  = r || f;
            if (e && m_pend[c] && c != g) m_ovf[c] = 1;
            else if (clr) m_ovf[c] = 0;
            if (md == 2'b00) m_pend[c] = 0;
            else if (e) begin
                if (!(m_pend[c] && c != g)) begin
                    m_pend[c]  = 1;
                    m_prise[c] = r;
                end
            end else if (c == g) m_pend[c] = 0;
            m_prev[c] = trig[c];
        end
        m_armed = 1;
    endtask

    task automatic check_model(string name);
        tests++;
        if (o_valid !== m_valid || o_ch !== 2'(m_ch) || o_rise !== m_rise || o_ovf !== m_ovf) begin
            fails++;
            $display("FAIL %s @%0t: got valid=%b ch=%0d rise=%b ovf=%b, want valid=%b ch=%0d rise=%b ovf=%b",
                     name, $time, o_valid, o_ch, o_rise, o_ovf, m_valid, m_ch, m_rise, m_ovf);
        end
    endtask

    task automatic check_exp(string name, logic vld, logic [1:0] ch, logic rise, logic [N-1:0] ovf);
        tests++;
        if (o_valid !== vld || o_ovf !== ovf || (vld && (o_ch !== ch || o_rise !== rise))) begin
            fails++;
            $display("FAIL %s @%0t: got valid=%b ch=%0d rise=%b ovf=%b, want valid=%b ch=%0d rise=%b ovf=%b",
                     name, $time, o_valid, o_ch, o_rise, o_ovf, vld, ch, rise, ovf);
        end
    endtask

    task automatic step(string name);
        @(posedge clk);
        model_clock();
        #1;
        check_model(name);
    endtask

    initial begin
        // {rst_n, trig, mode, rdy, clr, reps, exp valid, ch, rise, ovf}
        vec[0]  = '{1'b0, 4'b0101, 8'hFF, 1'b1, 1'b0, 2,  1'b0, 2'd0, 1'b0, 4'h0};
        vec[1]  = '{1'b1, 4'b0101, 8'hFF, 1'b1, 1'b0, 10, 1'b0, 2'd0, 1'b0, 4'h0};
        vec[2]  = '{1'b1, 4'b0101, 8'hAA, 1'b1, 1'b0, 1,  1'b0, 2'd0, 1'b0, 4'h0};
        vec[3]  = '{1'b1, 4'b0001, 8'hAA, 1'b1, 1'b0, 1,  1'b0, 2'd0, 1'b0, 4'h0};
        vec[4]  = '{1'b1, 4'b0001, 8'hAA, 1'b1, 1'b0, 1,  1'b1, 2'd2, 1'b0, 4'h0};
        vec[5]  = '{1'b1, 4'b0001, 8'hAA, 1'b1, 1'b0, 2,  1'b0, 2'd0, 1'b0, 4'h0};
        vec[6]  = '{1'b1, 4'b0000, 8'hAA, 1'b1, 1'b0, 1,  1'b0, 2'd0, 1'b0, 4'h0};
        vec[7]  = '{1'b1, 4'b0000, 8'hAA, 1'b1, 1'b0, 1,  1'b1, 2'd0, 1'b0, 4'h0};
        vec[8]  = '{1'b1, 4'b0000, 8'hAA, 1'b1, 1'b0, 1,  1'b0, 2'd0, 1'b0, 4'h0};
        vec[9]  = '{1'b1, 4'b0001, 8'hAA, 1'b1, 1'b0, 3,  1'b0, 2'd0, 1'b0, 4'h0};
        // Mode switched off on the same edge as a falling edge: not detected
        vec[10] = '{1'b1, 4'b0000, 8'h00, 1'b1, 1'b0, 3,  1'b0, 2'd0, 1'b0, 4'h0};

        for (int i = 0; i < NV; i++) begin
            rst_n = vec[i].rst_n; trig = vec[i].trig; mode = vec[i].mode;
            ready = vec[i].rdy;   clr  = vec[i].clr;
            for (int r = 0; r < vec[i].reps; r++) begin
                step($sformatf("vec%0d", i));
                check_exp($sformatf("vec%0d_exp", i), vec[i].vld, vec[i].ch, vec[i].rise, vec[i].ovf);
            end
        end

        // Round robin from a fresh reset: all channels rise, then all fall
        rst_n = 1'b0; mode = 8'hFF; trig = 4'b0000; ready = 1'b1;
        step("rr_rst");
        rst_n = 1'b1;
        step("rr_arm");
        step("rr_idle");
        trig = 4'b1111;
        step("rr_t0");
        check_exp("rr_t0_exp", 1'b0, 2'd0, 1'b0, 4'h0);
        for (int c = 0; c < N; c++) begin
            step("rr_rise");
            check_exp($sformatf("rr_rise_ch%0d", c), 1'b1, 2'(c), 1'b1, 4'h0);
        end
        step("rr_end");
        check_exp("rr_end_exp", 1'b0, 2'd0, 1'b0, 4'h0);
        trig = 4'b0000;
        step("rr2_t0");
        for (int c = 0; c < N; c++) begin
            step("rr_fall");
            check_exp($sformatf("rr_fall_ch%0d", c), 1'b1, 2'(c), 1'b0, 4'h0);
        end
        step("rr2_end");

        // Stalled output: held event, pending fall, third edge overflows
        ready = 1'b0; trig = 4'b0010;
        step("stall_t0");
        step("stall_p");
        check_exp("stall_p_exp", 1'b1, 2'd1, 1'b1, 4'h0);
        trig = 4'b0000;
        step("stall_fall");
        check_exp("stall_fall_exp", 1'b1, 2'd1, 1'b1, 4'h0);
        step("stall_hold");
        trig = 4'b0010;
        step("stall_ovf");
        check_exp("stall_ovf_exp", 1'b1, 2'd1, 1'b1, 4'b0010);
        step("stall_hold2");
        ready = 1'b1;
        step("stall_acc");
        check_exp("stall_acc_exp", 1'b1, 2'd1, 1'b0, 4'b0010);
        step("stall_drain");
        check_exp("stall_drain_exp", 1'b0, 2'd0, 1'b0, 4'b0010);
        clr = 1'b1;
        step("ovf_clr");
        check_exp("ovf_clr_exp", 1'b0, 2'd0, 1'b0, 4'h0);
        clr = 1'b0;

        // Ch3 edges again in its accept cycle: second event, no overflow
        ready = 1'b0; trig = 4'b1010;
        step("re_t0");
        step("re_p");
        check_exp("re_p_exp", 1'b1, 2'd3, 1'b1, 4'h0);
        step("re_hold");
        ready = 1'b1; trig = 4'b0010;
        step("re_acc");
        check_exp("re_acc_exp", 1'b0, 2'd0, 1'b0, 4'h0);
        step("re_2nd");
        check_exp("re_2nd_exp", 1'b1, 2'd3, 1'b0, 4'h0);
        step("re_end");

        // Reset while an event is stalled
        ready = 1'b0; trig = 4'b0011;
        step("rst_t0");
        step("rst_p");
        check_exp("rst_p_exp", 1'b1, 2'd0, 1'b1, 4'h0);
        rst_n = 1'b0;
        step("rst_mid");
        tests++;
        if (o_valid !== 1'b0 || o_ch !== 2'd0 || o_rise !== 1'b0 || o_ovf !== 4'h0) begin
            fails++;
            $display("FAIL rst_mid_outs: got valid=%b ch=%0d rise=%b ovf=%b, want all 0",
                     o_valid, o_ch, o_rise, o_ovf);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("rst_rearm");
            check_exp("rst_rearm_exp", 1'b0, 2'd0, 1'b0, 4'h0);
        end
        ready = 1'b1; trig = 4'b0010;
        step("rst_fall_t0");
        step("rst_fall");
        check_exp("rst_fall_exp", 1'b1, 2'd0, 1'b0, 4'h0);
        step("rst_fall_end");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) trig = trig ^ 4'(1 << $urandom_range(0, N - 1));
            if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 31) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
